// File: rtl/bcd_refresh_scheduler.sv
// Shares one iterative double-dabble binary-to-BCD engine across the seconds, minutes and hours fields.
// Optional macro ARB_FIXED_PRIO_EN: fixed sec > min > hr arbitration instead of round-robin.
module bcd_refresh_scheduler #(
    parameter int unsigned BIN_W     = 7,
    parameter int unsigned CLAMP_VAL = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] sec_bin,
    input  logic             sec_upd,
    input  logic [BIN_W-1:0] min_bin,
    input  logic             min_upd,
    input  logic [BIN_W-1:0] hr_bin,
    input  logic             hr_upd,
    output logic [3:0]       sec_tens,
    output logic [3:0]       sec_ones,
    output logic [3:0]       min_tens,
    output logic [3:0]       min_ones,
    output logic [3:0]       hr_tens,
    output logic [3:0]       hr_ones,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_ch,
    output logic             range_err
);

    localparam int unsigned      CntW    = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] ClampV  = BIN_W'(CLAMP_VAL);
    localparam logic [CntW-1:0]  LastCnt = CntW'(BIN_W - 1);
    localparam logic [1:0]       ChSec   = 2'd0;
    localparam logic [1:0]       ChMin   = 2'd1;
    localparam logic [1:0]       ChHr    = 2'd2;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StWrite} state_e;

    state_e           state_q;
    logic [2:0]       pend_q, pend_d, upd_vec, load_clr;
    logic [1:0]       last_q, grant_q, arb_ch;
    logic [BIN_W-1:0] val_q, sel_bin;
    logic [7:0]       bcd_q, bcd_adj;
    logic [CntW-1:0]  cnt_q;
    logic             clamp_q;
    logic [BIN_W+7:0] shifted;

    logic [3:0] sec_tens_q, sec_ones_q, min_tens_q, min_ones_q, hr_tens_q, hr_ones_q;
    logic       busy_q, done_q, range_err_q;
    logic [1:0] done_ch_q;

`ifndef ARB_FIXED_PRIO_EN
    // Channel index base+k modulo 3, for k in 1..3.
    function automatic logic [1:0] rr_step(input logic [1:0] base, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, k};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction
`endif

    assign upd_vec = {hr_upd, min_upd, sec_upd};

    always_comb begin
        arb_ch = ChSec;
`ifdef ARB_FIXED_PRIO_EN
        if (pend_q[0]) begin
            arb_ch = ChSec;
        end else if (pend_q[1]) begin
            arb_ch = ChMin;
        end else begin
            arb_ch = ChHr;
        end
`else
        // Scan farthest-first so the nearest pending channel after last_q wins.
        for (int k = 3; k >= 1; k--) begin
            if (pend_q[rr_step(last_q, 2'(k))]) begin
                arb_ch = rr_step(last_q, 2'(k));
            end
        end
`endif
    end

    always_comb begin
        case (grant_q)
            ChSec:   sel_bin = sec_bin;
            ChMin:   sel_bin = min_bin;
            default: sel_bin = hr_bin;
        endcase
    end

    // A new request on the channel being loaded survives the clear.
    assign load_clr = (state_q == StLoad) ? (3'b001 << grant_q) : 3'b000;
    assign pend_d   = (pend_q & ~load_clr) | upd_vec;

    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) begin
            bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        end
        if (bcd_q[7:4] >= 4'd5) begin
            bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
        end
    end

    assign shifted = {bcd_adj, val_q} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pend_q      <= 3'b000;
            last_q      <= ChHr;
            grant_q     <= ChSec;
            val_q       <= '0;
            bcd_q       <= 8'h00;
            cnt_q       <= '0;
            clamp_q     <= 1'b0;
            sec_tens_q  <= 4'd0;
            sec_ones_q  <= 4'd0;
            min_tens_q  <= 4'd0;
            min_ones_q  <= 4'd0;
            hr_tens_q   <= 4'd0;
            hr_ones_q   <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_ch_q   <= 2'd0;
            range_err_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (|pend_q) begin
                        grant_q <= arb_ch;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (sel_bin > ClampV) begin
                        val_q   <= ClampV;
                        clamp_q <= 1'b1;
                    end else begin
                        val_q   <= sel_bin;
                        clamp_q <= 1'b0;
                    end
                    bcd_q   <= 8'h00;
                    cnt_q   <= '0;
                    last_q  <= grant_q;
                    state_q <= StShift;
                end
                StShift: begin
                    bcd_q <= shifted[BIN_W+7:BIN_W];
                    val_q <= shifted[BIN_W-1:0];
                    cnt_q <= cnt_q + CntW'(1);
                    // done/range_err are registered so they line up with the WRITE cycle.
                    if (cnt_q == LastCnt) begin
                        done_q      <= 1'b1;
                        done_ch_q   <= grant_q;
                        range_err_q <= clamp_q;
                        state_q     <= StWrite;
                    end
                end
                StWrite: begin
                    case (grant_q)
                        ChSec: begin
                            sec_tens_q <= bcd_q[7:4];
                            sec_ones_q <= bcd_q[3:0];
                        end
                        ChMin: begin
                            min_tens_q <= bcd_q[7:4];
                            min_ones_q <= bcd_q[3:0];
                        end
                        default: begin
                            hr_tens_q <= bcd_q[7:4];
                            hr_ones_q <= bcd_q[3:0];
                        end
                    endcase
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sec_tens  = sec_tens_q;
    assign sec_ones  = sec_ones_q;
    assign min_tens  = min_tens_q;
    assign min_ones  = min_ones_q;
    assign hr_tens   = hr_tens_q;
    assign hr_ones   = hr_ones_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_ch   = done_ch_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_bcd_refresh_scheduler.sv
// Directed scoreboard bench for bcd_refresh_scheduler; honours ARB_FIXED_PRIO_EN for expected order.
module tb_bcd_refresh_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] sec_bin = 7'd0, min_bin = 7'd0, hr_bin = 7'd0;
    logic       sec_upd = 1'b0, min_upd = 1'b0, hr_upd = 1'b0;
    logic [3:0] sec_tens, sec_ones, min_tens, min_ones, hr_tens, hr_ones;
    logic       busy, done, range_err;
    logic [1:0] done_ch;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] ch;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       rerr;
        int         at;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mdl_tens[3];
    logic [3:0] mdl_ones[3];

    bcd_refresh_scheduler #(
        .BIN_W     (7),
        .CLAMP_VAL (99)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sec_bin   (sec_bin),
        .sec_upd   (sec_upd),
        .min_bin   (min_bin),
        .min_upd   (min_upd),
        .hr_bin    (hr_bin),
        .hr_upd    (hr_upd),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .hr_tens   (hr_tens),
        .hr_ones   (hr_ones),
        .busy      (busy),
        .done      (done),
        .done_ch   (done_ch),
        .range_err (range_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input int v, input int at);
        exp_t e;
        int   c;
        c      = (v > 99) ? 99 : v;
        e.ch   = ch;
        e.tens = 4'(c / 10);
        e.ones = 4'(c % 10);
        e.rerr = (v > 99);
        e.at   = at;
        sb.push_back(e);
    endtask

    // Called at a negedge; request is sampled at edge n, returns at the negedge after it.
    task automatic pulse(input logic [2:0] m, input int s, input int mi, input int h,
                         output int n);
        if (m[0]) sec_bin = 7'(s);
        if (m[1]) min_bin = 7'(mi);
        if (m[2]) hr_bin = 7'(h);
        sec_upd = m[0];
        min_upd = m[1];
        hr_upd  = m[2];
        n = cyc + 1;
        @(negedge clk);
        sec_upd = 1'b0;
        min_upd = 1'b0;
        hr_upd  = 1'b0;
    endtask

    task automatic check_digits();
        chk("sec_tens", sec_tens, mdl_tens[0]);
        chk("sec_ones", sec_ones, mdl_ones[0]);
        chk("min_tens", min_tens, mdl_tens[1]);
        chk("min_ones", min_ones, mdl_ones[1]);
        chk("hr_tens", hr_tens, mdl_tens[2]);
        chk("hr_ones", hr_ones, mdl_ones[2]);
    endtask

    task automatic wait_done();
        exp_t e;
        int   n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk("done_seen", done, 1);
        if (done === 1'b1) begin
            chk("done_cycle", cyc, e.at);
            chk("done_ch", done_ch, e.ch);
            chk("range_err", range_err, e.rerr);
            chk("busy_write", busy, 1);
            mdl_tens[e.ch] = e.tens;
            mdl_ones[e.ch] = e.ones;
            @(negedge clk);
            chk("done_pulse_end", done, 0);
            chk("range_err_end", range_err, 0);
            chk("busy_after", busy, 0);
            check_digits();
        end
    endtask

    initial begin
        int n0, n1, seen;
        for (int i = 0; i < 3; i++) begin
            mdl_tens[i] = 4'd0;
            mdl_ones[i] = 4'd0;
        end

        // Reset held two cycles, then twenty quiet cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_digits();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_done_ch", done_ch, 0);
        chk("reset_range_err", range_err, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        chk("idle_quiet", seen, 0);

        // Simultaneous requests from reset pointer: sec, min, hr ten cycles apart.
        pulse(3'b111, 7, 42, 23, n0);
        push(2'd0, 7, n0 + 9);
        push(2'd1, 42, n0 + 19);
        push(2'd2, 23, n0 + 29);
        wait_done();
        wait_done();
        wait_done();

        // Single seconds conversion latency.
        pulse(3'b001, 59, 0, 0, n0);
        push(2'd0, 59, n0 + 9);
        wait_done();

        // Saturating hours value.
        pulse(3'b100, 0, 0, 127, n0);
        push(2'd2, 127, n0 + 9);
        wait_done();

        // Pointer at hr; second sec request arrives during the min conversion.
        pulse(3'b111, 12, 34, 56, n0);
        push(2'd0, 12, n0 + 9);
        push(2'd1, 34, n0 + 19);
        wait_done();
        pulse(3'b001, 8, 0, 0, n1);
`ifdef ARB_FIXED_PRIO_EN
        push(2'd0, 8, n0 + 29);
        push(2'd2, 56, n0 + 39);
`else
        push(2'd2, 56, n0 + 29);
        push(2'd0, 8, n0 + 39);
`endif
        wait_done();
        wait_done();
        wait_done();

        // Clamp boundary: 99 passes, 100 saturates, 0 converts.
        pulse(3'b001, 99, 0, 0, n0);
        push(2'd0, 99, n0 + 9);
        wait_done();
        pulse(3'b010, 0, 100, 0, n0);
        push(2'd1, 100, n0 + 9);
        wait_done();
        pulse(3'b001, 0, 0, 0, n0);
        push(2'd0, 0, n0 + 9);
        wait_done();

        // Input change plus new request during SHIFT: snapshot kept, second run follows.
        pulse(3'b010, 0, 30, 0, n0);
        push(2'd1, 30, n0 + 9);
        repeat (3) @(negedge clk);
        pulse(3'b010, 0, 31, 0, n1);
        push(2'd1, 31, n0 + 19);
        wait_done();
        wait_done();

        // Reset mid-SHIFT aborts the conversion and clears everything.
        pulse(3'b001, 45, 0, 0, n0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mdl_tens[i] = 4'd0;
            mdl_ones[i] = 4'd0;
        end
        check_digits();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        chk("abort_quiet", seen, 0);

        // Reset restores the pointer to hr, so sec goes first.
        pulse(3'b101, 1, 0, 2, n0);
        push(2'd0, 1, n0 + 9);
        push(2'd2, 2, n0 + 19);
        wait_done();
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_refresh_scheduler.md
Name: bcd_refresh_scheduler

Overview:
Time-shares one iterative double-dabble binary-to-BCD engine among the clock's three display fields: seconds, minutes and hours. Each field raises an update pulse when its binary value changes. The scheduler arbitrates round-robin, converts the selected value to two BCD digits over several cycles, and holds registered digit outputs for the display driver. It sits between the timekeeping counters and the seven-segment decode logic.

Parameters:
BIN_W, 7, binary input width per field; shift count equals BIN_W.
CLAMP_VAL, 99, largest convertible value; inputs above it saturate to it.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
sec_bin  in  BIN_W  seconds value, unsigned
sec_upd  in  1  one-cycle request: seconds changed
min_bin  in  BIN_W  minutes value, unsigned
min_upd  in  1  one-cycle request: minutes changed
hr_bin  in  BIN_W  hours value, unsigned
hr_upd  in  1  one-cycle request: hours changed
sec_tens, sec_ones  out  4 each  seconds BCD digits
min_tens, min_ones  out  4 each  minutes BCD digits
hr_tens, hr_ones  out  4 each  hours BCD digits
busy  out  1  high while the engine is in LOAD, SHIFT or WRITE
done  out  1  one-cycle pulse when a channel's digits update
done_ch  out  2  channel written with done: 0=sec, 1=min, 2=hr
range_err  out  1  one-cycle pulse with done if the source was clamped

Behaviour:
- Reset (synchronous, sampled at the rising clk edge while rst=1):
  - All digit outputs 0; busy, done, range_err 0; done_ch 0.
  - Pending flags cleared; last-grant pointer set to hr, so sec has first priority.
  - FSM returns to IDLE. A conversion in flight is aborted and its result discarded.
- Pending flags, one per channel:
  - Set at the edge where the channel's upd=1.
  - Cleared at that channel's LOAD edge.
  - If upd and the LOAD clear coincide on the same channel, set wins, so a second conversion follows.
- FSM states: IDLE, LOAD, SHIFT, WRITE.
  - IDLE: if any flag is pending, grant the next pending channel after the last grant (order sec, min, hr, wrap to sec) and go to LOAD. Otherwise stay.
  - LOAD (1 cycle):
    - Snapshot the granted channel's *_bin as it is in this cycle.
    - If the snapshot exceeds CLAMP_VAL, substitute CLAMP_VAL and set an internal clamp flag.
    - Clear the BCD scratch register (8 bits) and the shift counter.
    - Update the last-grant pointer; go to SHIFT.
  - SHIFT (BIN_W cycles):
    - Each cycle, add 3 to each scratch nibble that is >= 5.
    - Then shift {scratch, value} left by 1 and increment the counter.
    - Leave for WRITE after BIN_W shifts.
  - WRITE (1 cycle):
    - Load the granted channel's tens/ones from the scratch register.
    - done=1, done_ch=the channel, range_err=the clamp flag.
    - Go to IDLE.
- Latency:
  - A upd at edge N with the engine idle: LOAD at N+1, WRITE at N+1+BIN_W+1.
  - Digits are visible at edge N+BIN_W+3, which is 10 cycles for BIN_W=7.
- Throughput: back-to-back conversions need one IDLE cycle between them, so 10 cycles per conversion.
- Input changes after LOAD do not affect the conversion in flight.
- Digit outputs for non-granted channels hold their values.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: IDLE grants by fixed priority, sec > min > hr, and the last-grant pointer is unused.
- Undefined (default): round-robin as above.
- Ports and latency are identical in both builds.

Test Plan:
- rst held 2 cycles, then released → all digits 0, busy=0, no done for 20 cycles.
- sec_bin=59 with one sec_upd pulse at edge N → done at N+9 with done_ch=0; sec_tens=5, sec_ones=9 at N+10; range_err=0.
- sec/min/hr upd in the same cycle with values 7, 42, 23 → three done pulses 10 cycles apart in order sec, min, hr. Digits 0/7, 4/2, 2/3. With ARB_FIXED_PRIO_EN the same order holds, and a repeated sec_upd preempts hr.
- hr_bin=127, hr_upd → hr_tens=9, hr_ones=9, range_err pulse coincident with done.
- min_upd with min_bin=30, then min_bin changes to 31 in the SHIFT phase together with a second min_upd → first result 3/0, then a second conversion gives 3/1.
- rst asserted mid-SHIFT of sec=45 → no done; sec digits 0; pending flags empty afterwards.
